// File: rtl/decim_sequencer.sv
// Sample/phase sequencer for the decimation filter: issues integrator and comb enables at R=2^k,
// drops the filter's settling results and buffers decimated results in a small FWFT FIFO.
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | stopped; enables quiet, FIFO still drainable
// WARMUP | counting, discarding the first ORDER datapath results
// RUN    | counting, pushing datapath results into the FIFO
module decim_sequencer #(
   parameter int DW         = 8,
   parameter int ORDER      = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          smp_valid,
   input  logic [2:0]    ratio_log2,
   output logic          integ_en,
   output logic          comb_en,
   input  logic          dp_valid,
   input  logic [DW-1:0] dp_data,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          overflow,
   output logic          busy
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int WW = $clog2(ORDER + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WARMUP = 2'd1,
      S_RUN    = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [2:0]      r_k_q;
   logic [6:0]      r_phase;
   logic [WW-1:0]   r_warm;
   logic            r_comb_en;
   logic            r_overflow;
   logic [DW-1:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [DW-1:0]   r_last;

   logic            w_busy;
   logic            w_in_warm;
   logic            w_in_run;
   logic            w_idle_exit;
   logic [7:0]      w_phase_max_full;
   logic [6:0]      w_phase_max;
   logic            w_phase_wrap;
   logic            w_out_valid;
   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic            w_push_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!ena) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   w_state_nxt = S_WARMUP;
            S_WARMUP: if (dp_valid && (r_warm == WW'(ORDER - 1))) w_state_nxt = S_RUN;
            S_RUN:    w_state_nxt = S_RUN;
            default:  w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_busy      = (r_state != S_IDLE);
      w_in_warm   = (r_state == S_WARMUP);
      w_in_run    = (r_state == S_RUN);
      w_idle_exit = (r_state == S_IDLE) && ena;
   end

   // Terminal count of the k_q-bit phase counter is 2^k_q - 1 (k_q is never 0).
   assign w_phase_max_full = (8'd1 << r_k_q) - 8'd1;
   assign w_phase_max      = w_phase_max_full[6:0];
   assign w_phase_wrap     = (r_phase == w_phase_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k_q     <= 3'd1;
         r_phase   <= '0;
         r_warm    <= '0;
         r_comb_en <= 1'b0;
      end else begin
         if (w_idle_exit) r_k_q <= (ratio_log2 == 3'd0) ? 3'd1 : ratio_log2;

         if (w_idle_exit)                r_warm <= '0;
         else if (w_in_warm && dp_valid) r_warm <= r_warm + WW'(1);

         if (!ena || !w_busy)   r_phase <= '0;
         else if (smp_valid)    r_phase <= w_phase_wrap ? 7'd0 : r_phase + 7'd1;

         r_comb_en <= ena && w_busy && smp_valid && w_phase_wrap;
      end
   end

   assign w_out_valid = (r_count != '0);
   assign w_full      = (r_count == CW'(FIFO_DEPTH));
   assign w_push      = w_in_run && dp_valid;
   assign w_pop       = w_out_valid && out_ready;
   assign w_push_ok   = w_push && (!w_full || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_last     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= dp_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_last   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_idle_exit)                    r_overflow <= 1'b0;
         else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   // While empty the head shows the most recently popped word.
   assign out_data  = w_out_valid ? r_mem[r_rd_ptr] : r_last;
   assign out_valid = w_out_valid;
   assign overflow  = r_overflow;
   assign comb_en   = r_comb_en;
   assign busy      = w_busy;
   assign integ_en  = smp_valid && w_busy;

endmodule

// File: tb/tb_decim_sequencer.sv
// Directed bench for decim_sequencer: a vector table for ratio/warm-up/FWFT behaviour,
// plus hand sequences for full-FIFO, overflow, ratio latching and mid-run reset.
module tb_decim_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       smp_valid = 1'b0;
   logic [2:0] ratio_log2 = 3'd0;
   logic       dp_valid = 1'b0;
   logic [7:0] dp_data = 8'h00;
   logic       out_ready = 1'b0;
   logic       integ_en;
   logic       comb_en;
   logic [7:0] out_data;
   logic       out_valid;
   logic       overflow;
   logic       busy;

   int n_err = 0;
   int n_chk = 0;

   typedef struct {
      logic       ena, smp, dpv, rdy;
      logic [2:0] ratio;
      logic [7:0] dpd;
      logic       x_integ, x_comb, x_ov;
      logic [7:0] x_od;
      logic       x_ovf, x_busy;
   } vec_t;

   vec_t tbl[$];

   decim_sequencer #(.DW(8), .ORDER(3), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .smp_valid  (smp_valid),
      .ratio_log2 (ratio_log2),
      .integ_en   (integ_en),
      .comb_en    (comb_en),
      .dp_valid   (dp_valid),
      .dp_data    (dp_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic s, input logic [2:0] r,
                        input logic dv, input logic [7:0] dd, input logic rdy);
      ena        = e;
      smp_valid  = s;
      ratio_log2 = r;
      dp_valid   = dv;
      dp_data    = dd;
      out_ready  = rdy;
   endtask

   task automatic step(input logic e, input logic s, input logic [2:0] r,
                       input logic dv, input logic [7:0] dd, input logic rdy);
      drive(e, s, r, dv, dd, rdy);
      cyc();
   endtask

   function automatic void add(input logic e, input logic s, input logic [2:0] r,
                               input logic dv, input logic [7:0] dd, input logic rdy,
                               input logic xi, input logic xc, input logic xov,
                               input logic [7:0] xod, input logic xovf, input logic xb);
      vec_t v;
      v.ena = e; v.smp = s; v.ratio = r; v.dpv = dv; v.dpd = dd; v.rdy = rdy;
      v.x_integ = xi; v.x_comb = xc; v.x_ov = xov; v.x_od = xod; v.x_ovf = xovf; v.x_busy = xb;
      tbl.push_back(v);
   endfunction

   initial begin
      // Ratio 4 on 16 back-to-back strobes, then warm-up discard of three results.
      add(1, 0, 3'd2, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0, 1);
      for (int i = 1; i <= 16; i++)
         add(1, 1, 3'd2, 0, 8'h00, 0,  1, (i % 4 == 0), 0, 8'h00, 0, 1);
      add(1, 0, 3'd5, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0, 1);
      add(1, 0, 3'd5, 1, 8'h11, 0,  0, 0, 0, 8'h00, 0, 1);
      add(1, 0, 3'd5, 1, 8'h22, 0,  0, 0, 0, 8'h00, 0, 1);
      add(1, 0, 3'd5, 1, 8'h33, 0,  0, 0, 0, 8'h00, 0, 1);
      add(1, 0, 3'd5, 1, 8'h44, 0,  0, 0, 1, 8'h44, 0, 1);
      add(1, 0, 3'd5, 1, 8'h55, 0,  0, 0, 1, 8'h44, 0, 1);
      add(1, 0, 3'd5, 0, 8'h00, 1,  0, 0, 1, 8'h55, 0, 1);
      add(1, 0, 3'd5, 0, 8'h00, 1,  0, 0, 0, 8'h55, 0, 1);

      cyc();
      cyc();
      chk("rst_comb_en", 8'(comb_en), 8'd0);
      chk("rst_out_valid", 8'(out_valid), 8'd0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_overflow", 8'(overflow), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_integ_en", 8'(integ_en), 8'd0);
      rst_n = 1'b1;
      cyc();

      foreach (tbl[n]) begin
         drive(tbl[n].ena, tbl[n].smp, tbl[n].ratio, tbl[n].dpv, tbl[n].dpd, tbl[n].rdy);
         #1;
         chk($sformatf("v%0d_integ_en", n), 8'(integ_en), 8'(tbl[n].x_integ));
         cyc();
         chk($sformatf("v%0d_comb_en", n), 8'(comb_en), 8'(tbl[n].x_comb));
         chk($sformatf("v%0d_out_valid", n), 8'(out_valid), 8'(tbl[n].x_ov));
         chk($sformatf("v%0d_out_data", n), out_data, tbl[n].x_od);
         chk($sformatf("v%0d_overflow", n), 8'(overflow), 8'(tbl[n].x_ovf));
         chk($sformatf("v%0d_busy", n), 8'(busy), 8'(tbl[n].x_busy));
      end

      // Full FIFO with simultaneous push and pop: no overflow, occupancy stays at four.
      for (int i = 0; i < 4; i++) step(1, 0, 3'd2, 1, 8'(8'hB0 + i), 0);
      chk("t4_full_ovf", 8'(overflow), 8'd0);
      chk("t4_full_head", out_data, 8'hB0);
      drive(1, 0, 3'd2, 1, 8'hB4, 1);
      #1;
      chk("t4_pop_head", out_data, 8'hB0);
      cyc();
      chk("t4_pushpop_ovf", 8'(overflow), 8'd0);
      chk("t4_pushpop_head", out_data, 8'hB1);
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 3'd2, 0, 8'h00, 1);
         #1;
         chk($sformatf("t4_drain%0d_valid", i), 8'(out_valid), 8'd1);
         chk($sformatf("t4_drain%0d_data", i), out_data, 8'(8'hB1 + i));
         cyc();
      end
      chk("t4_empty_valid", 8'(out_valid), 8'd0);
      chk("t4_empty_data", out_data, 8'hB4);

      // Five pushes with no consumer: fifth dropped, overflow sticks.
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 3'd2, 1, 8'(8'hA0 + i), 0);
         if (i == 3) chk("t3_ovf_at4", 8'(overflow), 8'd0);
      end
      chk("t3_ovf_at5", 8'(overflow), 8'd1);
      chk("t3_head", out_data, 8'hA0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 3'd2, 0, 8'h00, 1);
         #1;
         chk($sformatf("t3_pop%0d_valid", i), 8'(out_valid), 8'd1);
         chk($sformatf("t3_pop%0d_data", i), out_data, 8'(8'hA0 + i));
         cyc();
      end
      chk("t3_empty_valid", 8'(out_valid), 8'd0);
      chk("t3_empty_data", out_data, 8'hA3);
      chk("t3_ovf_sticky", 8'(overflow), 8'd1);

      // Ratio 0 acts as R=2, a change while busy is ignored, re-entry latches R=8.
      step(0, 0, 3'd0, 0, 8'h00, 0);
      chk("t5_idle_busy", 8'(busy), 8'd0);
      chk("t5_idle_ovf", 8'(overflow), 8'd1);
      drive(0, 1, 3'd0, 1, 8'hEE, 0);
      #1;
      chk("t5_idle_integ", 8'(integ_en), 8'd0);
      cyc();
      chk("t5_idle_dp_ignored", 8'(out_valid), 8'd0);
      chk("t5_idle_comb", 8'(comb_en), 8'd0);
      step(1, 0, 3'd0, 0, 8'h00, 0);
      chk("t5_start_busy", 8'(busy), 8'd1);
      chk("t5_start_ovf_clr", 8'(overflow), 8'd0);
      for (int i = 1; i <= 6; i++) begin
         step(1, 1, 3'd3, 0, 8'h00, 0);
         chk($sformatf("t5_r2_s%0d_comb", i), 8'(comb_en), 8'(i % 2 == 0));
      end
      step(1, 0, 3'd3, 0, 8'h00, 0);
      step(0, 0, 3'd3, 0, 8'h00, 0);
      step(1, 0, 3'd3, 0, 8'h00, 0);
      for (int i = 1; i <= 16; i++) begin
         step(1, 1, 3'd3, 0, 8'h00, 0);
         chk($sformatf("t5_r8_s%0d_comb", i), 8'(comb_en), 8'(i % 8 == 0));
      end

      // Reach RUN holding two entries with overflow set and a comb pulse live, then reset.
      for (int i = 0; i < 3; i++) step(1, 0, 3'd3, 1, 8'(8'h01 + i), 0);
      chk("t6_warm_discard", 8'(out_valid), 8'd0);
      for (int i = 0; i < 5; i++) step(1, 0, 3'd3, 1, 8'(8'hD0 + i), 0);
      chk("t6_ovf", 8'(overflow), 8'd1);
      step(1, 0, 3'd3, 0, 8'h00, 1);
      step(1, 0, 3'd3, 0, 8'h00, 1);
      chk("t6_two_left_valid", 8'(out_valid), 8'd1);
      chk("t6_two_left_head", out_data, 8'hD2);
      for (int i = 1; i <= 8; i++) step(1, 1, 3'd3, 0, 8'h00, 0);
      chk("t6_pre_rst_comb", 8'(comb_en), 8'd1);
      rst_n     = 1'b0;
      smp_valid = 1'b0;
      #1;
      chk("t6_rst_out_valid", 8'(out_valid), 8'd0);
      chk("t6_rst_comb_en", 8'(comb_en), 8'd0);
      chk("t6_rst_busy", 8'(busy), 8'd0);
      chk("t6_rst_overflow", 8'(overflow), 8'd0);
      chk("t6_rst_out_data", out_data, 8'h00);
      cyc();
      rst_n = 1'b1;
      step(0, 0, 3'd0, 0, 8'h00, 1);
      chk("t6_post_valid", 8'(out_valid), 8'd0);
      chk("t6_post_busy", 8'(busy), 8'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
